prog_delay_line: RTL and testbench
==================================

PROG_DELAY_LINE -- requirements
Module: prog_delay_line

Interface
REQ-001 SHALL have parameter WIDTH, default 8: sample data width in bits, legal range 1..64.
REQ-002 SHALL have parameter MAX_DLY, default 16: maximum delay in clock cycles, legal range 2..256.
REQ-003 SHALL have localparam DW = $clog2(MAX_DLY+1): delay-field width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port in_valid, input, 1 bit: in_data carries a sample this cycle.
REQ-007 SHALL have port in_data, input, WIDTH bits: input sample.
REQ-008 SHALL have port in_ready, output, 1 bit: the block accepts a sample this cycle.
REQ-009 SHALL have port cfg_load, input, 1 bit: request to change the delay to cfg_delay.
REQ-010 SHALL have port cfg_delay, input, DW bits: requested delay in cycles.
REQ-011 SHALL have port out_valid, output, 1 bit: out_data carries a delayed sample.
REQ-012 SHALL have port out_data, output, WIDTH bits: delayed sample.
REQ-013 SHALL have port cur_delay, output, DW bits: delay currently in force.
REQ-014 SHALL have port busy, output, 1 bit: a delay change is pending (DRAIN state).

Function
REQ-015 SHALL be a MAX_DLY-stage shift register with a per-stage valid bit; every stage advances each cycle with no stall.
REQ-016 SHALL accept a sample when in_valid && in_ready, and present it with out_valid=1 exactly cur_delay cycles later (input at edge N appears after edge N+cur_delay).
REQ-017 SHALL present samples in order with no loss, no duplication and no reordering; bubbles on the input SHALL appear as out_valid=0 cycles at the same spacing.
REQ-018 SHALL drive out_data to 0 whenever out_valid=0.
REQ-019 SHALL clamp cfg_delay: 0 -> 1, values above MAX_DLY -> MAX_DLY; the clamped value is the value applied.
REQ-020 SHALL have a two-state FSM, RUN and DRAIN.
REQ-021 RUN: in_ready=1 and busy=0. On cfg_load with no valid stage occupied, cur_delay SHALL update on that edge and the FSM SHALL stay in RUN.
REQ-022 RUN: on cfg_load with at least one valid stage occupied, the clamped value SHALL be latched as pending and the FSM SHALL go to DRAIN.
REQ-023 DRAIN: in_ready=0 and busy=1; in-flight samples SHALL exit at the old cur_delay.
REQ-024 DRAIN: when the last valid sample leaves, cur_delay SHALL take the pending value on the next edge and the FSM SHALL return to RUN.
REQ-025 SHALL ignore cfg_load while in DRAIN; the first pending value wins.
REQ-026 SHALL handle cfg_load and an accepted sample in the same RUN cycle by accepting the sample first: it counts as in flight and forces DRAIN.
REQ-027 SHALL keep an occupancy counter of 0..MAX_DLY valid stages, incremented on accept and decremented on out_valid, with both applied on the same edge netting zero; drain completion is occupancy==0.
REQ-028 SHALL accept in_data while in_ready=0 without effect and produce no X on any output.

Reset
REQ-029 SHALL, on rst_n low and independent of clk, immediately clear all valid bits and data stages and set occupancy to 0, FSM to RUN, cur_delay to MAX_DLY, pending to MAX_DLY, out_valid=0, out_data=0 and busy=0.
REQ-030 SHALL discard in-flight samples and any pending change if reset is asserted mid-DRAIN; after release the block SHALL be in RUN with cur_delay=MAX_DLY.
REQ-031 SHALL accept the first sample on the first rising edge after rst_n deasserts.

Verification
REQ-032 Basic delay: WIDTH=8, MAX_DLY=16, reset, then in_data 0x01..0x05 on consecutive cycles -> out_valid high for 5 cycles starting 16 cycles later, data 0x01..0x05.
REQ-033 Empty reconfiguration: cfg_load with cfg_delay=3 while idle -> cur_delay=3 next cycle, busy never asserted; a sample 0xA5 then appears 3 cycles after acceptance.
REQ-034 Drain: delay 3, sample 0x11, then cfg_load with cfg_delay=7 one cycle later -> busy=1 and in_ready=0 until 0x11 exits at 3 cycles; cur_delay=7 the next cycle, then a sample appears 7 cycles after acceptance.
REQ-035 Clamping: cfg_delay=0 -> cur_delay=1; cfg_delay=31 -> cur_delay=16.
REQ-036 Reset mid-DRAIN: assert rst_n low between clock edges during DRAIN -> outputs clear immediately and no stale sample appears after release.
REQ-037 Random traffic: random in_valid and cfg_load over 10k cycles, checked against a reference queue -> order preserved, latency equals cur_delay at acceptance, and occupancy never exceeds MAX_DLY.

Source files
------------

// File: rtl/prog_delay_line.sv
`default_nettype none
// ============================================================================
//  Module   : prog_delay_line
//  Purpose  : Programmable delay line. Every accepted sample re-appears on
//             the output exactly cur_delay cycles after it was presented.
//             Changing the delay while samples are in flight first drains the
//             line at the old delay, then switches to the new one.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1      rising-edge clock
//    rst_n      in   1      asynchronous active-low reset
//    in_valid   in   1      in_data carries a sample this cycle
//    in_data    in   WIDTH  input sample
//    in_ready   out  1      a sample is accepted this cycle (RUN state)
//    cfg_load   in   1      request a delay change to cfg_delay
//    cfg_delay  in   DW     requested delay (clamped to 1..MAX_DLY)
//    out_valid  out  1      out_data carries a delayed sample
//    out_data   out  WIDTH  delayed sample, 0 when out_valid is low
//    cur_delay  out  DW     delay currently in force
//    busy       out  1      a delay change is pending (DRAIN state)
// ============================================================================
module prog_delay_line #(
  parameter int WIDTH   = 8,
  parameter int MAX_DLY = 16,
  localparam int DW     = $clog2(MAX_DLY + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             cfg_load,
  input  logic [DW-1:0]    cfg_delay,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [DW-1:0]    cur_delay,
  output logic             busy
);

  // Index width for addressing one of the MAX_DLY stages.
  localparam int IW = $clog2(MAX_DLY);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [DW-1:0]     cur_q, cur_d;
  logic [DW-1:0]     pend_q, pend_d;
  logic [DW-1:0]     occ_q, occ_d;

  // Stage 0 is the output end of the line.
  logic              vld_q [MAX_DLY];
  logic              vld_d [MAX_DLY];
  logic [WIDTH-1:0]  dat_q [MAX_DLY];
  logic [WIDTH-1:0]  dat_d [MAX_DLY];

  logic              accept;
  logic [DW-1:0]     cfg_clamp;
  logic [IW-1:0]     wr_idx;

  assign in_ready = (state_q == ST_RUN);
  assign busy     = (state_q == ST_DRAIN);
  assign accept   = in_valid && in_ready;

  // A delay of d means the sample must reach stage 0 after d edges, so it
  // enters the line at stage d-1 (cur_q is never below 1).
  assign wr_idx   = IW'(cur_q - DW'(1));

  // --------------------------------------------------------------------------
  // Requested delay clamped into the legal 1..MAX_DLY window.
  // --------------------------------------------------------------------------
  always_comb begin
    cfg_clamp = cfg_delay;
    if (cfg_delay == '0) begin
      cfg_clamp = DW'(1);
    end else if (int'(cfg_delay) > MAX_DLY) begin
      cfg_clamp = DW'(MAX_DLY);
    end
  end

  // --------------------------------------------------------------------------
  // Shift line: every stage moves one step toward the output each cycle.
  // Stages at or above cur_q are always empty (the delay only changes when
  // the line is empty), so overwriting stage wr_idx never loses a sample.
  // Data of an empty stage is kept at zero so out_data is zero whenever
  // out_valid is low.
  // --------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < MAX_DLY - 1; i++) begin
      vld_d[i] = vld_q[i+1];
      dat_d[i] = dat_q[i+1];
    end
    vld_d[MAX_DLY-1] = 1'b0;
    dat_d[MAX_DLY-1] = '0;
    if (accept) begin
      vld_d[wr_idx] = 1'b1;
      dat_d[wr_idx] = in_data;
    end
  end

  // --------------------------------------------------------------------------
  // Occupancy: +1 on accept, -1 when a sample leaves, both together net 0.
  // --------------------------------------------------------------------------
  always_comb begin
    occ_d = occ_q;
    if (accept && !vld_q[0]) begin
      occ_d = occ_q + DW'(1);
    end else if (!accept && vld_q[0]) begin
      occ_d = occ_q - DW'(1);
    end
  end

  // --------------------------------------------------------------------------
  // RUN / DRAIN control.
  // A sample accepted in the same cycle as cfg_load is already in flight, so
  // it forces a drain even when the line was empty before this edge.
  // Drain finishes on the edge that removes the last sample, so the new delay
  // is visible in the cycle right after the last sample was presented.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    pend_d  = pend_q;
    case (state_q)
      ST_RUN: begin
        if (cfg_load) begin
          if ((occ_q == '0) && !accept) begin
            cur_d = cfg_clamp;
          end else begin
            pend_d  = cfg_clamp;
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // cfg_load is ignored here: the first pending value wins.
        if (occ_d == '0) begin
          cur_d   = pend_q;
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      cur_q   <= DW'(MAX_DLY);
      pend_q  <= DW'(MAX_DLY);
      occ_q   <= '0;
      for (int i = 0; i < MAX_DLY; i++) begin
        vld_q[i] <= 1'b0;
        dat_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      pend_q  <= pend_d;
      occ_q   <= occ_d;
      for (int i = 0; i < MAX_DLY; i++) begin
        vld_q[i] <= vld_d[i];
        dat_q[i] <= dat_d[i];
      end
    end
  end

  assign out_valid = vld_q[0];
  assign out_data  = vld_q[0] ? dat_q[0] : '0;
  assign cur_delay = cur_q;

endmodule
`default_nettype wire

// File: tb/tb_prog_delay_line.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prog_delay_line
//  Purpose  : Self-checking bench for prog_delay_line. A queue-based model
//             tracks every accepted sample with the cycle it must leave; the
//             DUT outputs are compared against it every cycle, alongside
//             hand-computed vectors for the directed scenarios.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_prog_delay_line;

  localparam int WIDTH   = 8;
  localparam int MAX_DLY = 16;
  localparam int DW      = $clog2(MAX_DLY + 1);

  logic             clk       = 1'b0;
  logic             rst_n     = 1'b1;
  logic             in_valid  = 1'b0;
  logic [WIDTH-1:0] in_data   = '0;
  logic             cfg_load  = 1'b0;
  logic [DW-1:0]    cfg_delay = '0;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [DW-1:0]    cur_delay;
  logic             busy;

  prog_delay_line #(
    .WIDTH   (WIDTH),
    .MAX_DLY (MAX_DLY)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .cfg_load  (cfg_load),
    .cfg_delay (cfg_delay),
    .out_valid (out_valid),
    .out_data  (out_data),
    .cur_delay (cur_delay),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- reference model ----------------
  typedef struct {
    logic [WIDTH-1:0] data;
    int               exit_cyc;
  } item_t;

  item_t q[$];
  int    cyc     = 0;        // index of the current cycle
  int    m_cur   = MAX_DLY;
  int    m_pend  = MAX_DLY;
  bit    m_drain = 1'b0;

  function automatic int clamp(input int v);
    if (v < 1) return 1;
    if (v > MAX_DLY) return MAX_DLY;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_cur   = MAX_DLY;
    m_pend  = MAX_DLY;
    m_drain = 1'b0;
  endtask

  task automatic check_model();
    logic             e_ov;
    logic [WIDTH-1:0] e_dat;
    e_ov  = 1'b0;
    e_dat = '0;
    if (q.size() > 0) begin
      if (q[0].exit_cyc == cyc) begin
        e_ov  = 1'b1;
        e_dat = q[0].data;
      end
    end
    chk("model out_valid", 64'(out_valid), 64'(e_ov));
    chk("model out_data",  64'(out_data),  64'(e_dat));
    chk("model in_ready",  64'(in_ready),  64'(!m_drain));
    chk("model busy",      64'(busy),      64'(m_drain));
    chk("model cur_delay", 64'(cur_delay), 64'(m_cur));
  endtask

  // Applies the rules for one rising edge using the inputs presented now.
  task automatic model_edge();
    bit acc;
    int occ_before;
    acc        = in_valid && !m_drain;
    occ_before = q.size();
    if (q.size() > 0) begin
      if (q[0].exit_cyc == cyc) void'(q.pop_front());
    end
    if (acc) q.push_back('{in_data, cyc + m_cur});
    if (!m_drain) begin
      if (cfg_load) begin
        if (occ_before == 0 && !acc) begin
          m_cur = clamp(int'(cfg_delay));
        end else begin
          m_pend  = clamp(int'(cfg_delay));
          m_drain = 1'b1;
        end
      end
    end else if (q.size() == 0) begin
      m_cur   = m_pend;
      m_drain = 1'b0;
    end
    cyc++;
  endtask

  // Present inputs (called just after a rising edge), then check mid-cycle.
  task automatic drive(input logic v, input logic [WIDTH-1:0] d,
                       input logic cl, input logic [DW-1:0] cd);
    in_valid  = v;
    in_data   = d;
    cfg_load  = cl;
    cfg_delay = cd;
    @(negedge clk);
    check_model();
  endtask

  task automatic advance();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic             v;
    logic [WIDTH-1:0] d;
    logic             cl;
    logic [DW-1:0]    cd;
    logic             eov;
    logic [WIDTH-1:0] edat;
    logic [DW-1:0]    ecur;
    logic             ebusy;
  } vec_t;

  vec_t tbl [10];

  initial begin
    // clamp + empty reconfiguration; expectations are for the same cycle
    tbl[0] = '{1'b0, 8'h00, 1'b1, 5'd0,  1'b0, 8'h00, 5'd16, 1'b0};
    tbl[1] = '{1'b0, 8'h00, 1'b0, 5'd0,  1'b0, 8'h00, 5'd1,  1'b0};
    tbl[2] = '{1'b0, 8'h00, 1'b1, 5'd31, 1'b0, 8'h00, 5'd1,  1'b0};
    tbl[3] = '{1'b0, 8'h00, 1'b0, 5'd0,  1'b0, 8'h00, 5'd16, 1'b0};
    tbl[4] = '{1'b0, 8'h00, 1'b1, 5'd3,  1'b0, 8'h00, 5'd16, 1'b0};
    tbl[5] = '{1'b1, 8'hA5, 1'b0, 5'd0,  1'b0, 8'h00, 5'd3,  1'b0};
    tbl[6] = '{1'b0, 8'h00, 1'b0, 5'd0,  1'b0, 8'h00, 5'd3,  1'b0};
    tbl[7] = '{1'b0, 8'h00, 1'b0, 5'd0,  1'b0, 8'h00, 5'd3,  1'b0};
    tbl[8] = '{1'b0, 8'h00, 1'b0, 5'd0,  1'b1, 8'hA5, 5'd3,  1'b0};
    tbl[9] = '{1'b0, 8'h00, 1'b0, 5'd0,  1'b0, 8'h00, 5'd3,  1'b0};

    // ---- power-on reset ----
    #1 rst_n = 1'b0;
    #1;
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset out_data",  64'(out_data),  64'd0);
    chk("reset busy",      64'(busy),      64'd0);
    chk("reset in_ready",  64'(in_ready),  64'd1);
    chk("reset cur_delay", 64'(cur_delay), 64'd16);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    model_reset();

    // ---- basic delay: 0x01..0x05 back to back, delay 16 ----
    for (int k = 0; k < 23; k++) begin
      drive(k < 5, WIDTH'(k + 1), 1'b0, '0);
      chk("basic out_valid", 64'(out_valid), 64'(k >= 16 && k <= 20));
      chk("basic out_data",  64'(out_data),  (k >= 16 && k <= 20) ? 64'(k - 15) : 64'd0);
      advance();
    end

    // ---- table: clamping and empty reconfiguration ----
    for (int k = 0; k < 10; k++) begin
      drive(tbl[k].v, tbl[k].d, tbl[k].cl, tbl[k].cd);
      chk("tbl out_valid", 64'(out_valid), 64'(tbl[k].eov));
      chk("tbl out_data",  64'(out_data),  64'(tbl[k].edat));
      chk("tbl cur_delay", 64'(cur_delay), 64'(tbl[k].ecur));
      chk("tbl busy",      64'(busy),      64'(tbl[k].ebusy));
      advance();
    end

    // ---- drain: delay 3, sample 0x11, then cfg_load 7 ----
    drive(1'b1, 8'h11, 1'b0, '0);
    chk("drain c0 busy", 64'(busy), 64'd0);
    advance();
    drive(1'b0, 8'h00, 1'b1, 5'd7);
    chk("drain c1 busy", 64'(busy), 64'd0);
    advance();
    drive(1'b0, 8'h00, 1'b0, '0);
    chk("drain c2 busy",     64'(busy),      64'd1);
    chk("drain c2 in_ready", 64'(in_ready),  64'd0);
    chk("drain c2 cur",      64'(cur_delay), 64'd3);
    advance();
    drive(1'b0, 8'h00, 1'b1, 5'd2);          // ignored while draining
    chk("drain c3 out_valid", 64'(out_valid), 64'd1);
    chk("drain c3 out_data",  64'(out_data),  64'h11);
    chk("drain c3 busy",      64'(busy),      64'd1);
    advance();
    drive(1'b1, 8'h22, 1'b0, '0);
    chk("drain c4 busy",     64'(busy),      64'd0);
    chk("drain c4 cur",      64'(cur_delay), 64'd7);
    chk("drain c4 in_ready", 64'(in_ready),  64'd1);
    advance();
    for (int k = 5; k <= 11; k++) begin
      drive(1'b0, 8'h00, 1'b0, '0);
      chk("drain new out_valid", 64'(out_valid), 64'(k == 11));
      chk("drain new out_data",  64'(out_data),  (k == 11) ? 64'h22 : 64'd0);
      advance();
    end

    // ---- reset in the middle of a drain ----
    drive(1'b1, 8'h33, 1'b0, '0);
    advance();
    drive(1'b0, 8'h00, 1'b1, 5'd2);
    advance();
    drive(1'b0, 8'h00, 1'b0, '0);
    chk("middrain busy", 64'(busy), 64'd1);
    advance();
    #2 rst_n = 1'b0;
    #1;
    chk("async rst out_valid", 64'(out_valid), 64'd0);
    chk("async rst out_data",  64'(out_data),  64'd0);
    chk("async rst busy",      64'(busy),      64'd0);
    chk("async rst in_ready",  64'(in_ready),  64'd1);
    chk("async rst cur_delay", 64'(cur_delay), 64'd16);
    @(posedge clk);
    #2;
    chk("held rst busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < 12; k++) begin
      drive(1'b0, 8'h00, 1'b0, '0);
      chk("post rst no stale", 64'(out_valid), 64'd0);
      advance();
    end

    // ---- random traffic ----
    for (int k = 0; k < 10000; k++) begin
      drive(1'($urandom_range(0, 9) < 6), WIDTH'($urandom),
            1'($urandom_range(0, 99) < 3), DW'($urandom_range(0, 31)));
      advance();
    end
    for (int k = 0; k < 20; k++) begin
      drive(1'b0, 8'h00, 1'b0, '0);
      advance();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
